ones_pattern_gen: RTL and testbench

//  Inverse companion of the popcount block: given a target weight K, enumerates every

---
 rtl/ones_pattern_gen.sv | 192 +++++++++++++++++++
 tb/tb_ones_pattern_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ones_pattern_gen.sv
// Gosper-sequence word generator: streams every DATA_W-bit word with exactly K ones,
// ascending, over valid/ready. Optional checker enabled by ONES_PATTERN_GEN_CHECK_EN.
module ones_pattern_gen #(
  parameter int DATA_W  = 32,
  parameter int WT_W    = $clog2(DATA_W+1),
  parameter int LIMIT_W = 16
) (
  input  logic               clk,
  input  logic               counter_reset,
  input  logic               start,
  input  logic [WT_W-1:0]    weight,
  input  logic [LIMIT_W-1:0] limit,
  output logic               busy,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [LIMIT_W-1:0] words_sent,
  output logic               done,
  output logic               err_weight
`ifdef ONES_PATTERN_GEN_CHECK_EN
  ,
  output logic               check_err
`endif
);

  localparam int CTZ_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [LIMIT_W-1:0]  ws_q, ws_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [LIMIT_W-1:0]  limit_q, limit_d;

  logic                xfer;
  logic                wt_ok;
  logic [DATA_W-1:0]   init_word, max_word;
  logic [DATA_W-1:0]   lsb, ripple, gnext;
  logic [CTZ_W-1:0]    ctz;
  logic [LIMIT_W-1:0]  ws_inc;
  logic                gnext_lim;

  assign xfer  = valid_q & out_ready;
  assign wt_ok = 32'(weight) <= DATA_W;

  // Shifts by >= DATA_W yield zero, so K=0 and K=DATA_W fall out naturally.
  assign init_word = ~({DATA_W{1'b1}} << weight);
  assign max_word  = ~({DATA_W{1'b1}} >> weight);

  // Gosper step; c is one-hot, so dividing by it is a right shift by ctz(c).
  always_comb begin
    lsb    = data_q & (-data_q);
    ripple = data_q + lsb;
    ctz    = '0;
    for (int i = 0; i < DATA_W; i++)
      if (lsb[i]) ctz = ctz | CTZ_W'(i);
    gnext  = (((ripple ^ data_q) >> 2) >> ctz) | ripple;
  end

  assign ws_inc    = (&ws_q) ? ws_q : ws_q + LIMIT_W'(1);
  assign gnext_lim = (limit_q != '0) &&
                     ({1'b0, ws_inc} + (LIMIT_W+1)'(1) == {1'b0, limit_q});

`ifdef ONES_PATTERN_GEN_CHECK_EN
  logic [WT_W-1:0]   k_q, k_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
  logic              chk_q, chk_d;
  logic [WT_W-1:0]   pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_W; i++)
      pop = pop + WT_W'(data_q[i]);
  end

  always_comb begin
    k_d         = k_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    chk_d       = chk_q;
    if (state_q == IDLE && start && wt_ok) begin
      k_d         = weight;
      have_prev_d = 1'b0;
      chk_d       = 1'b0;
    end else if (state_q == RUN && xfer) begin
      if (pop != k_q || (have_prev_q && data_q <= prev_q)) chk_d = 1'b1;
      prev_d      = data_q;
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge counter_reset) begin
    if (!counter_reset) begin
      k_q         <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      chk_q       <= 1'b0;
    end else begin
      k_q         <= k_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      chk_q       <= chk_d;
    end
  end

  assign check_err = chk_q;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    ws_d    = ws_q;
    max_d   = max_q;
    limit_d = limit_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (wt_ok) begin
            state_d = RUN;
            data_d  = init_word;
            valid_d = 1'b1;
            last_d  = (init_word == max_word) || (limit == LIMIT_W'(1));
            ws_d    = '0;
            max_d   = max_word;
            limit_d = limit;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          ws_d = ws_inc;
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d = gnext;
            last_d = (gnext == max_q) || gnext_lim;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge counter_reset) begin
    if (!counter_reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ws_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      max_q   <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ws_q    <= ws_d;
      done_q  <= done_d;
      err_q   <= err_d;
      max_q   <= max_d;
      limit_q <= limit_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign words_sent = ws_q;
  assign done       = done_q;
  assign err_weight = err_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen: fixed-weight streams, limits, stalls, errors, reset.
module tb_ones_pattern_gen;

  logic        clk = 1'b0;
  logic        counter_reset;
  logic        start;
  logic [5:0]  weight;
  logic [15:0] limit;
  logic        busy;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] words_sent;
  logic        done;
  logic        err_weight;
`ifdef ONES_PATTERN_GEN_CHECK_EN
  logic        check_err;
`endif

  ones_pattern_gen dut (
    .clk(clk), .counter_reset(counter_reset), .start(start), .weight(weight),
    .limit(limit), .busy(busy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .words_sent(words_sent),
    .done(done), .err_weight(err_weight)
`ifdef ONES_PATTERN_GEN_CHECK_EN
    , .check_err(check_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] got[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int k, input int lim);
    start = 1'b1; weight = 6'(k); limit = 16'(lim);
    tick();
    start = 1'b0;
  endtask

  // Collects words until the out_last transfer; returns at +1 after that edge.
  // poke >= 0 pulses a start (weight 1) on that cycle to prove it is ignored.
  task automatic collect(input int rnd, input int budget, input int poke, output int bad_stable);
    int cyc; logic stalled; logic [31:0] held; logic last_seen;
    got.delete();
    cyc = 0; stalled = 1'b0; held = '0; last_seen = 1'b0; bad_stable = 0;
    while (!last_seen && cyc < budget) begin
      out_ready = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == poke) begin start = 1'b1; weight = 6'd1; limit = 16'd1; end
      else start = 1'b0;
      if (stalled && (!out_valid || out_data !== held)) bad_stable++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_last) last_seen = 1'b1;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        held    = out_data;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("last_seen_in_budget", 64'(last_seen), 64'd1);
  endtask

  initial begin
    int bs, bad;
    logic [31:0] v;
    logic [31:0] t1 [6] = '{32'h3, 32'h5, 32'h6, 32'h9, 32'hA, 32'hC};
    logic [31:0] t2 [4] = '{32'h7, 32'hB, 32'hD, 32'hE};
    logic [31:0] t5 [6] = '{32'h7, 32'hB, 32'hD, 32'hE, 32'h13, 32'h15};
    logic [31:0] t6 [3] = '{32'h1, 32'h2, 32'h4};

    counter_reset = 1'b0; start = 1'b0; weight = '0; limit = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ws", 64'(words_sent), 64'd0);
    chk("rst_flags", 64'({out_last, done, err_weight}), 64'd0);
    counter_reset = 1'b1;
    tick();

    // K=2, unlimited: all C(32,2)=496 words, popcount 2 and strictly increasing
    do_start(2, 0);
    chk("k2_first_valid", 64'(out_valid), 64'd1);
    chk("k2_first_word", 64'(out_data), 64'h3);
    collect(0, 1000, -1, bs);
    chk("k2_count", 64'(got.size()), 64'd496);
    for (int i = 0; i < 6; i++) chk($sformatf("k2_word%0d", i), 64'(got[i]), 64'(t1[i]));
    chk("k2_final", 64'(got[got.size()-1]), 64'hC0000000);
    bad = 0;
    for (int i = 0; i < got.size(); i++) begin
      if ($countones(got[i]) != 2) bad++;
      if (i > 0 && got[i] <= got[i-1]) bad++;
    end
    chk("k2_stream_props", 64'(bad), 64'd0);
    chk("k2_done", 64'(done), 64'd1);
    chk("k2_idle", 64'({busy, out_valid}), 64'd0);
    chk("k2_ws", 64'(words_sent), 64'd496);
    tick();
    chk("k2_done_1cyc", 64'(done), 64'd0);
    chk("k2_ws_held", 64'(words_sent), 64'd496);

    // K=3 with limit 4
    do_start(3, 4);
    collect(0, 50, -1, bs);
    chk("k3l4_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("k3l4_word%0d", i), 64'(got[i]), 64'(t2[i]));
    chk("k3l4_ws", 64'(words_sent), 64'd4);
    chk("k3l4_busy", 64'(busy), 64'd0);

    // Degenerate weights
    do_start(0, 0);
    chk("k0_last", 64'({out_valid, out_last}), 64'h3);
    collect(0, 10, -1, bs);
    chk("k0_count", 64'(got.size()), 64'd1);
    chk("k0_word", 64'(got[0]), 64'h0);
    do_start(32, 0);
    chk("k32_last", 64'({out_valid, out_last}), 64'h3);
    collect(0, 10, -1, bs);
    chk("k32_count", 64'(got.size()), 64'd1);
    chk("k32_word", 64'(got[0]), 64'hFFFFFFFF);
    chk("k32_ws", 64'(words_sent), 64'd1);

    // Illegal weight
    out_ready = 1'b1;
    do_start(33, 0);
    chk("err_pulse", 64'(err_weight), 64'd1);
    chk("err_no_valid", 64'({out_valid, busy}), 64'd0);
    chk("err_ws_kept", 64'(words_sent), 64'd1);
    tick();
    chk("err_1cyc", 64'(err_weight), 64'd0);
    chk("err_still_idle", 64'(out_valid), 64'd0);

    // Start during RUN is ignored
    do_start(3, 6);
    collect(0, 50, 2, bs);
    chk("poke_count", 64'(got.size()), 64'd6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk($sformatf("poke_word%0d", i), 64'(got[i]), 64'(t5[i]));
    chk("poke_ws", 64'(words_sent), 64'd6);

    // K=5 with random backpressure against a brute-force popcount scan
    do_start(5, 40);
    collect(1, 2000, -1, bs);
    chk("k5_stall_stable", 64'(bs), 64'd0);
    chk("k5_count", 64'(got.size()), 64'd40);
    bad = 0; v = 0;
    for (int i = 0; i < 40 && i < got.size(); i++) begin
      while ($countones(v) != 5) v++;
      if (got[i] !== v) bad++;
      v++;
    end
    chk("k5_ref_seq", 64'(bad), 64'd0);
    chk("k5_ws", 64'(words_sent), 64'd40);

    // Async reset mid-run, then a fresh run
    do_start(4, 0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("k4_running", 64'({busy, out_valid}), 64'h3);
    #2 counter_reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_busy_ws", 64'({busy, words_sent}), 64'd0);
    chk("mid_rst_last", 64'(out_last), 64'd0);
    tick();
    counter_reset = 1'b1;
    tick();
    do_start(1, 3);
    collect(0, 20, -1, bs);
    chk("k1_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk($sformatf("k1_word%0d", i), 64'(got[i]), 64'(t6[i]));
`ifdef ONES_PATTERN_GEN_CHECK_EN
    chk("check_err", 64'(check_err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
